// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix-multiply scheduler.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_SIZE_A = 32;

  // Full-precision width of an unsigned dot product of size_a elements.
  function automatic int unsigned result_width(input int unsigned elem_w,
                                               input int unsigned size_a);
    return 2 * elem_w + int'($clog2(size_a));
  endfunction

  // Product register stage plus one register per adder level.
  function automatic int unsigned pipe_depth(input int unsigned size_a);
    return 1 + int'($clog2(size_a));
  endfunction

  localparam int unsigned PIPE_DEPTH = pipe_depth(DEF_SIZE_A);

endpackage

// File: rtl/matmul_scheduler_dot_product_tree.sv
// Fully pipelined unsigned dot product: registered products, then a
// registered pairwise adder tree; valid and an opaque tag ride alongside.
module dot_product_tree
  import matmul_pkg::*;
#(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned N      = 32,
  parameter int unsigned TAG_W  = 10,
  localparam int unsigned VEC_W = N * ELEM_W,
  localparam int unsigned SUM_W = result_width(ELEM_W, N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [VEC_W-1:0] a_vec,
  input  logic [VEC_W-1:0] b_vec,
  output logic             valid_out,
  output logic [TAG_W-1:0] tag_out,
  output logic [SUM_W-1:0] sum_out,
  output logic             inflight_c
);

  localparam int unsigned PROD_W = 2 * ELEM_W;
  localparam int unsigned LEVELS = $clog2(N);
  localparam int unsigned DEPTH  = pipe_depth(N);

  logic [PROD_W-1:0] prod_d [N];
  logic [PROD_W-1:0] prod_q [N];
  logic [DEPTH-1:0]  valid_d, valid_q;
  logic [TAG_W-1:0]  tag_d [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH];

  // Element k sits at the MSB end for k = 0.
  for (genvar k = 0; k < N; k++) begin : g_prod
    localparam int unsigned HI = VEC_W - 1 - ELEM_W * k;
    assign prod_d[k] = PROD_W'(a_vec[HI -: ELEM_W]) * PROD_W'(b_vec[HI -: ELEM_W]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prod_q[k] <= '0;
      else        prod_q[k] <= prod_d[k];
    end
  end

  // Each level halves the operand count and grows one bit, so no overflow.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned CNT = N >> (l + 1);
    localparam int unsigned LW  = PROD_W + l + 1;
    logic [LW-1:0] sum_d [CNT];
    logic [LW-1:0] sum_q [CNT];

    for (genvar m = 0; m < CNT; m++) begin : g_add
      if (l == 0) begin : g_first
        assign sum_d[m] = LW'(prod_q[2*m]) + LW'(prod_q[2*m+1]);
      end else begin : g_rest
        assign sum_d[m] = LW'(g_lvl[l-1].sum_q[2*m]) + LW'(g_lvl[l-1].sum_q[2*m+1]);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q[m] <= '0;
        else        sum_q[m] <= sum_d[m];
      end
    end
  end

  assign valid_d = {valid_q[DEPTH-2:0], valid_in};

  for (genvar s = 0; s < DEPTH; s++) begin : g_tag
    if (s == 0) begin : g_head
      assign tag_d[s] = tag_in;
    end else begin : g_body
      assign tag_d[s] = tag_q[s-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_q[s] <= '0;
      else        tag_q[s] <= tag_d[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  assign valid_out  = valid_q[DEPTH-1];
  assign tag_out    = tag_q[DEPTH-1];
  assign sum_out    = g_lvl[LEVELS-1].sum_q[0];
  assign inflight_c = |valid_q[DEPTH-2:0];

endmodule

// File: rtl/matmul_scheduler.sv
// Walks all (A row, B column) pairs, requests vectors from the loader and
// streams tagged dot products. Optional tag checking: MATMUL_ADDR_CHECK_EN.
module matmul_scheduler
  import matmul_pkg::*;
#(
  parameter int unsigned MAX_ELEMENT_SIZE = 8,
  parameter int unsigned MAX_SIZE_A       = 32,
  parameter int unsigned MAX_SIZE_B       = 32,
  localparam int unsigned A_W      = $clog2(MAX_SIZE_A),
  localparam int unsigned B_W      = $clog2(MAX_SIZE_B),
  localparam int unsigned VEC_W    = MAX_SIZE_A * MAX_ELEMENT_SIZE,
  localparam int unsigned RESULT_W = result_width(MAX_ELEMENT_SIZE, MAX_SIZE_A)
) (
  input  logic                inter_refclk,
  input  logic                rst_n,
  input  logic                start,
  output logic                valid_request,
  output logic [A_W-1:0]      requested_a_row,
  output logic [B_W-1:0]      requested_b_col,
  input  logic                valid_in,
  input  logic [A_W-1:0]      a_addr_in,
  input  logic [B_W-1:0]      b_addr_in,
  input  logic [VEC_W-1:0]    a_row_in,
  input  logic [VEC_W-1:0]    b_col_in,
  output logic                result_valid,
  output logic [A_W-1:0]      result_row,
  output logic [B_W-1:0]      result_col,
  output logic [RESULT_W-1:0] result,
  output logic                busy,
  output logic                done,
  output logic                addr_error
);

  localparam int unsigned OUT_W = $clog2(MAX_SIZE_A * MAX_SIZE_B) + 1;
  localparam int unsigned TAG_W = A_W + B_W;

  state_e           state_q, state_d;
  logic             valid_request_q, valid_request_d;
  logic [A_W-1:0]   row_q, row_d;
  logic [B_W-1:0]   col_q, col_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_c, start_c, last_req_c, inflight_c;
  logic [TAG_W-1:0] res_tag;

  // Loader data is only meaningful while a pass is running.
  assign accept_c   = valid_in && (state_q != IDLE);
  assign start_c    = start && (state_q == IDLE);
  assign last_req_c = valid_request_q && (row_q == A_W'(MAX_SIZE_A - 1)) &&
                      (col_q == B_W'(MAX_SIZE_B - 1));

  always_comb begin
    state_d         = state_q;
    valid_request_d = 1'b0;
    row_d           = row_q;
    col_d           = col_q;
    done_d          = 1'b0;
    outstanding_d   = outstanding_q + OUT_W'(valid_request_q) - OUT_W'(accept_c);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d         = ISSUE;
          valid_request_d = 1'b1;
          row_d           = '0;
          col_d           = '0;
          outstanding_d   = '0;
        end
      end
      ISSUE: begin
        if (last_req_c) begin
          state_d = DRAIN;
        end else begin
          valid_request_d = 1'b1;
          if (col_q == B_W'(MAX_SIZE_B - 1)) begin
            col_d = '0;
            row_d = row_q + A_W'(1);
          end else begin
            col_d = col_q + B_W'(1);
          end
        end
      end
      DRAIN: begin
        // The final result sits in the output register on the exit cycle.
        if ((outstanding_q == '0) && !inflight_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      valid_request_q <= 1'b0;
      row_q           <= '0;
      col_q           <= '0;
      outstanding_q   <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_request_q <= valid_request_d;
      row_q           <= row_d;
      col_q           <= col_d;
      outstanding_q   <= outstanding_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign valid_request   = valid_request_q;
  assign requested_a_row = row_q;
  assign requested_b_col = col_q;
  assign busy            = busy_q;
  assign done            = done_q;

`ifdef MATMUL_ADDR_CHECK_EN
  logic [A_W-1:0] exp_i_q, exp_i_d;
  logic [B_W-1:0] exp_j_q, exp_j_d;
  logic           addr_error_q, addr_error_d;

  // Returns must follow the same row-major order as the requests.
  always_comb begin
    exp_i_d      = exp_i_q;
    exp_j_d      = exp_j_q;
    addr_error_d = addr_error_q;
    if (start_c) begin
      exp_i_d      = '0;
      exp_j_d      = '0;
      addr_error_d = 1'b0;
    end else if (accept_c) begin
      if ((a_addr_in != exp_i_q) || (b_addr_in != exp_j_q) || (outstanding_q == '0)) begin
        addr_error_d = 1'b1;
      end
      if (exp_j_q == B_W'(MAX_SIZE_B - 1)) begin
        exp_j_d = '0;
        exp_i_d = exp_i_q + A_W'(1);
      end else begin
        exp_j_d = exp_j_q + B_W'(1);
      end
    end
  end

  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) begin
      exp_i_q      <= '0;
      exp_j_q      <= '0;
      addr_error_q <= 1'b0;
    end else begin
      exp_i_q      <= exp_i_d;
      exp_j_q      <= exp_j_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign addr_error = addr_error_q;
`else
  logic unused_start_c;
  assign unused_start_c = start_c;
  assign addr_error     = 1'b0;
`endif

  dot_product_tree #(
    .ELEM_W (MAX_ELEMENT_SIZE),
    .N      (MAX_SIZE_A),
    .TAG_W  (TAG_W)
  ) u_tree (
    .clk        (inter_refclk),
    .rst_n      (rst_n),
    .valid_in   (accept_c),
    .tag_in     ({a_addr_in, b_addr_in}),
    .a_vec      (a_row_in),
    .b_vec      (b_col_in),
    .valid_out  (result_valid),
    .tag_out    (res_tag),
    .sum_out    (result),
    .inflight_c (inflight_c)
  );

  assign {result_row, result_col} = res_tag;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Self-checking bench for matmul_scheduler with a 3-cycle loader model.
module tb_matmul_scheduler;

  localparam int AW = 5;
  localparam int BW = 5;
  localparam int SA = 32;
  localparam int SB = 32;
  localparam int VW = 256;
  localparam int RW = 21;

  logic          inter_refclk;
  logic          rst_n, start, valid_request, valid_in;
  logic          result_valid, busy, done, addr_error;
  logic [AW-1:0] requested_a_row, a_addr_in, result_row;
  logic [BW-1:0] requested_b_col, b_addr_in, result_col;
  logic [VW-1:0] a_row_in, b_col_in;
  logic [RW-1:0] result;

  matmul_scheduler dut (
    .inter_refclk    (inter_refclk),
    .rst_n           (rst_n),
    .start           (start),
    .valid_request   (valid_request),
    .requested_a_row (requested_a_row),
    .requested_b_col (requested_b_col),
    .valid_in        (valid_in),
    .a_addr_in       (a_addr_in),
    .b_addr_in       (b_addr_in),
    .a_row_in        (a_row_in),
    .b_col_in        (b_col_in),
    .result_valid    (result_valid),
    .result_row      (result_row),
    .result_col      (result_col),
    .result          (result),
    .busy            (busy),
    .done            (done),
    .addr_error      (addr_error)
  );

  initial inter_refclk = 1'b0;
  always #5 inter_refclk = ~inter_refclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  bit corrupt_en = 0;
  int req_cnt, res_cnt, done_cnt, mism, ret_cnt;
  int first_req_cyc, last_req_cyc, first_res_cyc, last_res_cyc, done_cyc, first_vi_cyc;
  int spot_r, spot_c, spot_val, last_row, last_col;
  bit err_seen;
  bit s_v [3];
  int s_r [3];
  int s_c [3];

  typedef struct {
    int mode;
    bit glitch;
    int spot_r;
    int spot_c;
    int spot_exp;
  } vec_t;
  vec_t vecs [4];

  function automatic int elem_a(int md, int r, int k);
    case (md)
      0:       return (r == k) ? 1 : 0;
      1:       return 255;
      default: return r;
    endcase
  endfunction

  function automatic int elem_b(int md, int k, int c);
    case (md)
      0:       return (k >= 0) ? 1 : 0;
      1:       return 255;
      default: return c;
    endcase
  endfunction

  function automatic int dot(int md, int r, int c);
    int s = 0;
    for (int k = 0; k < SA; k++) s += elem_a(md, r, k) * elem_b(md, k, c);
    return s;
  endfunction

  function automatic logic [VW-1:0] pack_a(int md, int r);
    logic [VW-1:0] v = '0;
    for (int k = 0; k < SA; k++) v[VW-1-8*k -: 8] = 8'(elem_a(md, r, k));
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_b(int md, int c);
    logic [VW-1:0] v = '0;
    for (int k = 0; k < SA; k++) v[VW-1-8*k -: 8] = 8'(elem_b(md, k, c));
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_request"}, int'(valid_request), 0);
    check({tag, "_req_addr"}, int'({requested_a_row, requested_b_col}), 0);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_result_tag"}, int'({result_row, result_col}), 0);
    check({tag, "_busy_done_err"}, int'({busy, done, addr_error}), 0);
  endtask

  task automatic clear_counts();
    req_cnt = 0; res_cnt = 0; done_cnt = 0; mism = 0; ret_cnt = 0;
    first_req_cyc = -1; last_req_cyc = -1; first_res_cyc = -1; last_res_cyc = -1;
    done_cyc = -1; first_vi_cyc = -1; spot_val = -1; last_row = -1; last_col = -1;
    err_seen = 0;
  endtask

  always @(posedge inter_refclk) cyc <= cyc + 1;

  // Monitor and loader model; DUT outputs are stable at the falling edge.
  always @(negedge inter_refclk) begin
    int er, ec;
    if (valid_request) begin
      if (req_cnt == 0) first_req_cyc = cyc;
      last_req_cyc = cyc;
      req_cnt++;
    end
    if (result_valid) begin
      if (res_cnt == 0) first_res_cyc = cyc;
      last_res_cyc = cyc;
      er = res_cnt / SB;
      ec = res_cnt % SB;
      if (int'(result_row) != er || int'(result_col) != ec || int'(result) != dot(mode, er, ec))
        mism++;
      if (int'(result_row) == spot_r && int'(result_col) == spot_c) spot_val = int'(result);
      last_row = int'(result_row);
      last_col = int'(result_col);
      res_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (addr_error) err_seen = 1;

    valid_in  = s_v[2];
    a_addr_in = AW'(s_r[2]);
    b_addr_in = BW'(s_c[2]);
    if (s_v[2] && busy) begin
      if (first_vi_cyc < 0) first_vi_cyc = cyc;
      if (corrupt_en && ret_cnt == 9) b_addr_in = b_addr_in ^ BW'(1);
      ret_cnt++;
    end
    a_row_in = pack_a(mode, s_r[2]);
    b_col_in = pack_b(mode, s_c[2]);
    s_v[2] = s_v[1]; s_r[2] = s_r[1]; s_c[2] = s_c[1];
    s_v[1] = s_v[0]; s_r[1] = s_r[0]; s_c[1] = s_c[0];
    s_v[0] = valid_request;
    s_r[0] = int'(requested_a_row);
    s_c[0] = int'(requested_b_col);
  end

  task automatic run_pass(input int md, input bit glitch, input bit corrupt);
    int t;
    clear_counts();
    mode = md;
    corrupt_en = corrupt;
    @(negedge inter_refclk);
    start = 1'b1;
    @(negedge inter_refclk);
    start = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(negedge inter_refclk);
      t++;
      start = (glitch && (t == 200 || t == 1030)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    repeat (4) @(negedge inter_refclk);
  endtask

  task automatic check_pass(input string tag, input int exp_spot);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_result_count"}, res_cnt, 1024);
    check({tag, "_request_count"}, req_cnt, 1024);
    check({tag, "_request_span"}, last_req_cyc - first_req_cyc, 1023);
    check({tag, "_result_span"}, last_res_cyc - first_res_cyc, 1023);
    check({tag, "_result_mismatches"}, mism, 0);
    check({tag, "_done_after_last"}, done_cyc - last_res_cyc, 1);
    check({tag, "_latency"}, first_res_cyc - first_vi_cyc, 6);
    check({tag, "_spot_value"}, spot_val, exp_spot);
    check({tag, "_last_tag"}, last_row * 32 + last_col, 31 * 32 + 31);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; start = 1'b0; valid_in = 1'b0;
    a_addr_in = '0; b_addr_in = '0; a_row_in = '0; b_col_in = '0;
    for (int i = 0; i < 3; i++) begin s_v[i] = 0; s_r[i] = 0; s_c[i] = 0; end
    spot_r = 0; spot_c = 0;
    clear_counts();

    vecs[0] = '{mode: 0, glitch: 1'b0, spot_r: 7,  spot_c: 20, spot_exp: 1};
    vecs[1] = '{mode: 1, glitch: 1'b0, spot_r: 31, spot_c: 31, spot_exp: 2080800};
    vecs[2] = '{mode: 2, glitch: 1'b0, spot_r: 31, spot_c: 31, spot_exp: 30752};
    vecs[3] = '{mode: 2, glitch: 1'b1, spot_r: 3,  spot_c: 5,  spot_exp: 480};

    repeat (3) @(negedge inter_refclk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge inter_refclk);

    for (int v = 0; v < 4; v++) begin
      spot_r = vecs[v].spot_r;
      spot_c = vecs[v].spot_c;
      run_pass(vecs[v].mode, vecs[v].glitch, 1'b0);
      check_pass($sformatf("pass%0d", v), vecs[v].spot_exp);
    end

    // Abort a pass at request 500 with an asynchronous reset.
    clear_counts();
    mode = 2;
    @(negedge inter_refclk);
    start = 1'b1;
    @(negedge inter_refclk);
    start = 1'b0;
    t = 0;
    while (req_cnt < 500 && t < 2000) begin
      @(negedge inter_refclk);
      t++;
    end
    check("abort_reached_500", int'(req_cnt >= 500), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge inter_refclk);
    @(negedge inter_refclk);
    rst_n = 1'b1;
    clear_counts();
    repeat (8) @(negedge inter_refclk);
    check("late_data_results", res_cnt, 0);
    check("late_data_busy", int'(busy), 0);
    spot_r = 31; spot_c = 31;
    run_pass(2, 1'b0, 1'b0);
    check_pass("after_abort", 30752);

    // Corrupted column tag on the tenth return.
    spot_r = 0; spot_c = 0;
    run_pass(0, 1'b0, 1'b1);
    check("corrupt_result_count", res_cnt, 1024);
    check("corrupt_done_count", done_cnt, 1);
`ifdef MATMUL_ADDR_CHECK_EN
    check("corrupt_addr_error", int'(addr_error), 1);
    check("corrupt_addr_error_seen", int'(err_seen), 1);
`else
    check("corrupt_addr_error", int'(addr_error), 0);
    check("corrupt_addr_error_seen", int'(err_seen), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
